// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between a show-ahead sample FIFO and an Avalon-ST FFT sink.
// Buffers one full frame, streams it with SOP/EOP, then waits for the FFT result.
module fft_frame_sequencer #(
  parameter int FRAME_LEN   = 8192,
  parameter int DATA_W      = 16,
  parameter int USEDW_W     = 14,
  parameter int IDX_W       = 13,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_rdempty,
  input  logic [USEDW_W-1:0] fifo_rdusedw,
  output logic               fifo_rdreq,
  input  logic               sink_ready,
  output logic               sink_valid,
  output logic               sink_sop,
  output logic               sink_eop,
  output logic [DATA_W-1:0]  sink_real,
  output logic [DATA_W-1:0]  sink_imag,
  output logic [1:0]         sink_error,
  input  logic               source_valid,
  input  logic               source_eop,
  output logic               source_ready,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               underflow_err,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [USEDW_W-1:0] FILL_LEVEL = USEDW_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_FILL   = 2'b01,
    STREAM      = 2'b10,
    WAIT_RESULT = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               frame_done_q;
  logic [15:0]        frame_count_q;
  logic               underflow_q;
  logic               timeout_q;
  logic               src_ready_q;
  logic               eop_hit;
  logic               tmo_hit;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    fifo_rdreq = 1'b0;
    eop_hit    = 1'b0;
    tmo_hit    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fifo_rdusedw >= FILL_LEVEL) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        // Show-ahead FIFO: the head word is presented directly, popping only on a real transfer.
        sink_valid = !fifo_rdempty;
        sink_sop   = sink_valid && (idx_q == '0);
        sink_eop   = sink_valid && (idx_q == LAST_IDX);
        fifo_rdreq = sink_valid && sink_ready;
        if (fifo_rdreq) begin
          if (idx_q == LAST_IDX) begin
            state_d = WAIT_RESULT;
            idx_d   = '0;
            tmo_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_RESULT: begin
        tmo_d = tmo_q + 1'b1;
        // A result EOP on the final allowed cycle still counts as a completed frame.
        if (source_valid && source_eop) begin
          eop_hit = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      underflow_q   <= 1'b0;
      timeout_q     <= 1'b0;
      src_ready_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      frame_done_q <= eop_hit;
      src_ready_q  <= 1'b1;
      if (eop_hit) frame_count_q <= frame_count_q + 16'd1;
      if (state_q == STREAM && fifo_rdempty) underflow_q <= 1'b1;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign sink_real     = (state_q == STREAM) ? fifo_q : '0;
  assign sink_imag     = '0;
  assign sink_error    = 2'b00;
  assign source_ready  = src_ready_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign underflow_err = underflow_q;
  assign timeout_err   = timeout_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: a vector table for the streaming datapath
// plus hand-written sequences for stalls, underflow, result wait, timeout and reset.
module tb_fft_frame_sequencer;

  localparam int FRAME_LEN = 8192;
  localparam int TMO       = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] fifo_q;
  logic        fifo_rdempty;
  logic [13:0] fifo_rdusedw;
  logic        fifo_rdreq;
  logic        sink_ready;
  logic        sink_valid, sink_sop, sink_eop;
  logic [15:0] sink_real, sink_imag;
  logic [1:0]  sink_error;
  logic        source_valid, source_eop, source_ready;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        underflow_err, timeout_err;
  logic [1:0]  state_dbg;

  always #10 clk = ~clk;

  fft_frame_sequencer dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rdreq   (fifo_rdreq),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .source_valid (source_valid),
    .source_eop   (source_eop),
    .source_ready (source_ready),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .underflow_err(underflow_err),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    logic        empty;
    logic        ready;
    logic [15:0] q;
    logic        exp_valid;
    logic        exp_rdreq;
    logic        exp_sop;
    logic        exp_eop;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_err    = 0;

  int n_xfer, n_sop, n_eop;
  int rd_empty_bad = 0, outside_bad = 0, sop_bad = 0, eop_bad = 0, data_bad = 0;
  int stall_pop, gap_valid;
  logic        s_valid, s_rdreq, s_sop, s_eop, s_done;
  logic [15:0] s_real;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock edge: sample just before the edge, return 1 time unit after it.
  task automatic cyc();
    @(negedge clk);
    #5;
    s_valid = sink_valid;
    s_rdreq = fifo_rdreq;
    s_sop   = sink_sop;
    s_eop   = sink_eop;
    s_real  = sink_real;
    s_done  = frame_done;
    if (fifo_rdreq && fifo_rdempty) rd_empty_bad++;
    if (state_dbg != 2'd2 && (sink_valid || fifo_rdreq || sink_sop || sink_eop)) outside_bad++;
    if (sink_valid && sink_real !== fifo_q) data_bad++;
    if (sink_sop !== (sink_valid && n_xfer == 0)) sop_bad++;
    if (sink_eop !== (sink_valid && n_xfer == FRAME_LEN - 1)) eop_bad++;
    if (fifo_rdreq) begin
      n_xfer++;
      if (sink_sop) n_sop++;
      if (sink_eop) n_eop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_xfer = 0; n_sop = 0; n_eop = 0; stall_pop = 0; gap_valid = 0;
  endtask

  // Streams while in STREAM; optional 3-cycle ready stall, 5-cycle empty gap, enable drop, early stop.
  task automatic stream_frame(input int stall_at, input int gap_at, input int drop_at, input int stop_at);
    int stall_left = 3;
    int gap_left   = 5;
    for (int c = 0; c < 9000 && state_dbg == 2'd2 && n_xfer != stop_at; c++) begin
      fifo_q       = 16'(n_xfer) ^ 16'h5A5A;
      sink_ready   = 1'b1;
      fifo_rdempty = 1'b0;
      if (n_xfer == drop_at) enable = 1'b0;
      if (n_xfer == stall_at && stall_left > 0) begin
        sink_ready = 1'b0;
        stall_left--;
        cyc();
        if (s_rdreq) stall_pop++;
      end else if (n_xfer == gap_at && gap_left > 0) begin
        if (gap_left == 5) check("underflow_before_gap", 32'(underflow_err), 32'd0);
        fifo_rdempty = 1'b1;
        gap_left--;
        cyc();
        if (s_valid) gap_valid++;
      end else begin
        cyc();
      end
    end
    fifo_rdempty = 1'b0;
    sink_ready   = 1'b1;
  endtask

  // Waits in WAIT_RESULT; source_valid alone one cycle before EOP, EOP on cycle eop_at (0 = never).
  task automatic wait_result(input int eop_at, output int cycles);
    cycles = 0;
    while (state_dbg == 2'd3 && cycles < TMO + 5000) begin
      cycles++;
      source_valid = (cycles == eop_at - 1) || (cycles == eop_at);
      source_eop   = (cycles == eop_at);
      cyc();
    end
    source_valid = 1'b0;
    source_eop   = 1'b0;
  endtask

  initial begin
    #(100_000 * 20 * 2);
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    vecs[0] = '{empty: 1'b0, ready: 1'b0, q: 16'h1111, exp_valid: 1'b1, exp_rdreq: 1'b0, exp_sop: 1'b1, exp_eop: 1'b0};
    vecs[1] = '{empty: 1'b0, ready: 1'b1, q: 16'h1234, exp_valid: 1'b1, exp_rdreq: 1'b1, exp_sop: 1'b1, exp_eop: 1'b0};
    vecs[2] = '{empty: 1'b0, ready: 1'b0, q: 16'hBEEF, exp_valid: 1'b1, exp_rdreq: 1'b0, exp_sop: 1'b0, exp_eop: 1'b0};
    vecs[3] = '{empty: 1'b0, ready: 1'b1, q: 16'hCAFE, exp_valid: 1'b1, exp_rdreq: 1'b1, exp_sop: 1'b0, exp_eop: 1'b0};
    vecs[4] = '{empty: 1'b0, ready: 1'b1, q: 16'h0001, exp_valid: 1'b1, exp_rdreq: 1'b1, exp_sop: 1'b0, exp_eop: 1'b0};
    vecs[5] = '{empty: 1'b0, ready: 1'b0, q: 16'hFFFF, exp_valid: 1'b1, exp_rdreq: 1'b0, exp_sop: 1'b0, exp_eop: 1'b0};

    reset = 1'b1; enable = 1'b0; fifo_q = '0; fifo_rdempty = 1'b1; fifo_rdusedw = '0;
    sink_ready = 1'b0; source_valid = 1'b0; source_eop = 1'b0;
    clear_counts();

    // Reset state
    #5;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_source_ready", 32'(source_ready), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_flags", {29'd0, frame_done, underflow_err, timeout_err}, 32'd0);
    check("rst_sink_const", {14'd0, sink_error, sink_imag}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_source_ready_held", 32'(source_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("release_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    check("source_ready_after_release", 32'(source_ready), 32'd1);

    // One sample short of a frame: stays in WAIT_FILL; result EOP here is ignored
    enable = 1'b1; fifo_rdusedw = 14'd8191; fifo_rdempty = 1'b0; fifo_q = 16'h1111; sink_ready = 1'b1;
    waited = 0;
    for (int i = 0; i < 6; i++) begin
      source_valid = (i == 3); source_eop = (i == 3);
      cyc();
      if (s_valid || s_rdreq || s_done) waited++;
    end
    source_valid = 1'b0; source_eop = 1'b0;
    check("wait_fill_state", 32'(state_dbg), 32'd1);
    check("wait_fill_quiet", 32'(waited), 32'd0);
    check("wait_fill_no_count", 32'(frame_count), 32'd0);
    enable = 1'b0; cyc();
    check("wait_fill_enable_drop", 32'(state_dbg), 32'd0);
    enable = 1'b1; cyc();
    check("reenable_state", 32'(state_dbg), 32'd1);
    fifo_rdusedw = 14'd8192; cyc();
    check("fill_to_stream", 32'(state_dbg), 32'd2);

    // Datapath vector table at the start of frame 1
    for (int i = 0; i < 6; i++) begin
      fifo_rdempty = vecs[i].empty;
      sink_ready   = vecs[i].ready;
      fifo_q       = vecs[i].q;
      cyc();
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_rdreq", i), 32'(s_rdreq), 32'(vecs[i].exp_rdreq));
      check($sformatf("vec%0d_sop", i),   32'(s_sop),   32'(vecs[i].exp_sop));
      check($sformatf("vec%0d_eop", i),   32'(s_eop),   32'(vecs[i].exp_eop));
      check($sformatf("vec%0d_real", i),  32'(s_real),  32'(vecs[i].q));
    end

    // Rest of frame 1: ready stall at 100, empty gap at 3000, enable dropped at 5000
    stream_frame(100, 3000, 5000, -1);
    check("f1_state", 32'(state_dbg), 32'd3);
    check("f1_transfers", 32'(n_xfer), 32'd8192);
    check("f1_sop_count", 32'(n_sop), 32'd1);
    check("f1_eop_count", 32'(n_eop), 32'd1);
    check("f1_stall_pops", 32'(stall_pop), 32'd0);
    check("f1_gap_valid", 32'(gap_valid), 32'd0);
    check("f1_underflow", 32'(underflow_err), 32'd1);

    wait_result(500, waited);
    check("f1_result_cycles", 32'(waited), 32'd500);
    check("f1_frame_done", 32'(frame_done), 32'd1);
    check("f1_frame_count", 32'(frame_count), 32'd1);
    check("f1_state_idle", 32'(state_dbg), 32'd0);
    check("f1_no_timeout", 32'(timeout_err), 32'd0);
    cyc();
    check("f1_done_pulse_end", 32'(frame_done), 32'd0);
    check("f1_idle_enable_low", 32'(state_dbg), 32'd0);

    // Frame 2: EOP on the last allowed cycle wins over timeout
    enable = 1'b1; clear_counts();
    cyc(); cyc();
    check("f2_stream", 32'(state_dbg), 32'd2);
    stream_frame(-1, -1, -1, -1);
    check("f2_transfers", 32'(n_xfer), 32'd8192);
    wait_result(TMO, waited);
    check("f2_result_cycles", 32'(waited), 32'(TMO));
    check("f2_frame_done", 32'(frame_done), 32'd1);
    check("f2_frame_count", 32'(frame_count), 32'd2);
    check("f2_no_timeout", 32'(timeout_err), 32'd0);

    // Frame 3: no result EOP, timeout
    clear_counts();
    cyc(); cyc();
    check("f3_stream", 32'(state_dbg), 32'd2);
    stream_frame(-1, -1, -1, -1);
    check("f3_transfers", 32'(n_xfer), 32'd8192);
    wait_result(0, waited);
    check("f3_timeout_cycles", 32'(waited), 32'(TMO));
    check("f3_timeout_err", 32'(timeout_err), 32'd1);
    check("f3_frame_count", 32'(frame_count), 32'd2);
    check("f3_no_done", 32'(frame_done), 32'd0);
    check("f3_state_idle", 32'(state_dbg), 32'd0);
    check("f3_underflow_sticky", 32'(underflow_err), 32'd1);

    // Frame 4: asynchronous reset at idx 4000
    clear_counts();
    cyc(); cyc();
    stream_frame(-1, -1, -1, 4000);
    check("f4_at_4000", 32'(n_xfer), 32'd4000);
    #3;
    check("f4_valid_before_reset", 32'(sink_valid && fifo_rdreq), 32'd1);
    reset = 1'b1;
    #1;
    check("f4_reset_outputs", {28'd0, sink_valid, fifo_rdreq, sink_sop, sink_eop}, 32'd0);
    check("f4_reset_state", 32'(state_dbg), 32'd0);
    check("f4_reset_count", 32'(frame_count), 32'd0);
    check("f4_reset_flags", {30'd0, underflow_err, timeout_err}, 32'd0);
    check("f4_reset_source_ready", 32'(source_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("f4_release_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    check("f4_wait_fill", 32'(state_dbg), 32'd1);

    // Frame 5 starts cleanly at idx 0
    clear_counts();
    cyc();
    check("f5_stream", 32'(state_dbg), 32'd2);
    fifo_q = 16'h7E57;
    cyc();
    check("f5_first_sop", {28'd0, s_valid, s_rdreq, s_sop, s_eop}, 32'b1110);
    check("f5_first_real", 32'(s_real), 32'h7E57);

    check("never_pop_empty", 32'(rd_empty_bad), 32'd0);
    check("quiet_outside_stream", 32'(outside_bad), 32'd0);
    check("sop_position", 32'(sop_bad), 32'd0);
    check("eop_position", 32'(eop_bad), 32'd0);
    check("data_path", 32'(data_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
